fatigue_alarm_ctrl: RTL and testbench

FATIGUE_ALARM_CTRL -- requirements
Module: fatigue_alarm_ctrl

---
 rtl/fatigue_alarm_ctrl_pkg.sv | 23 ++
 rtl/fatigue_alarm_ctrl_div.sv | 68 ++++++
 rtl/fatigue_alarm_ctrl.sv | 167 ++++++++++++++++
 tb/tb_fatigue_alarm_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fatigue_alarm_ctrl_pkg.sv
// fatigue_alarm_ctrl_pkg: alarm level encoding, counter widths
// and a saturating increment shared by the controller and divider.
package fatigue_alarm_ctrl_pkg;

  localparam int CNT_W     = 13;
  localparam int DIVD_W    = 20;
  localparam int PCT_W     = 7;
  localparam int PCT_SCALE = 100;

  typedef enum logic [1:0] {
    LVL_NORMAL = 2'd0,
    LVL_WARN   = 2'd1,
    LVL_ALARM  = 2'd2,
    LVL_HOLD   = 2'd3
  } level_e;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/fatigue_alarm_ctrl_div.sv
// perclos_div: restoring divider, one quotient bit per cycle.
// Ports: start/dividend/divisor in; done pulse + quotient out.
module perclos_div
  import fatigue_alarm_ctrl_pkg::*;
(
  input  logic              module_clk,
  input  logic              module_rst_n,
  input  logic              start,
  input  logic [DIVD_W-1:0] dividend,
  input  logic [CNT_W-1:0]  divisor,
  output logic              done,
  output logic [PCT_W-1:0]  quotient
);

  logic [CNT_W-1:0]  rem;
  logic [CNT_W-1:0]  rem_in;
  logic [CNT_W-1:0]  rem_nx;
  logic [CNT_W:0]    rem_sh;
  logic [CNT_W:0]    diff;
  logic [DIVD_W-1:0] quo;
  logic [DIVD_W-1:0] quo_in;
  logic [DIVD_W-1:0] quo_nx;
  logic [4:0]        left;
  logic              busy;
  logic              ge;

  // The start cycle already performs the first step, so the
  // last of the 20 steps lands 19 edges after the load edge.
  always_comb begin
    rem_in = start ? '0 : rem;
    quo_in = start ? dividend : quo;
    rem_sh = {rem_in, quo_in[DIVD_W-1]};
    diff   = rem_sh - {1'b0, divisor};
    // rem_sh < 2*divisor, so the top bit of diff is a borrow.
    ge     = ~diff[CNT_W];
    rem_nx = ge ? diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
    quo_nx = {quo_in[DIVD_W-2:0], ge};
  end

  always_ff @(posedge module_clk or negedge module_rst_n) begin
    if (!module_rst_n) begin
      rem      <= '0;
      quo      <= '0;
      left     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem  <= rem_nx;
        quo  <= quo_nx;
        left <= 5'(DIVD_W - 1);
        busy <= 1'b1;
      end else if (busy) begin
        rem  <= rem_nx;
        quo  <= quo_nx;
        left <= left - 5'd1;
        if (left == 5'd1) begin
          busy     <= 1'b0;
          done     <= 1'b1;
          quotient <= quo_nx[PCT_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/fatigue_alarm_ctrl.sv
// fatigue_alarm_ctrl: PERCLOS window + long-closure alarm FSM.
// Ports: frame/eye/ack in; beep, alarm_level, perclos_pct/vld out.
module fatigue_alarm_ctrl
  import fatigue_alarm_ctrl_pkg::*;
#(
  parameter int WIN_FRAMES   = 5400,
  parameter int WARN_PCT     = 15,
  parameter int ALARM_PCT    = 40,
  parameter int LX_FRAMES    = 120,
  parameter int HOLD_FRAMES  = 300,
  parameter int BLINK_FRAMES = 15
) (
  input  logic             module_clk,
  input  logic             module_rst_n,
  input  logic             frame_start,
  input  logic             eye_valid,
  input  logic             eye_closed,
  input  logic             ack_key,
  output logic             beep,
  output logic [1:0]       alarm_level,
  output logic [PCT_W-1:0] perclos_pct,
  output logic             perclos_vld
);

  logic [CNT_W-1:0]  win_cnt;
  logic [CNT_W-1:0]  close_cnt;
  logic [CNT_W-1:0]  close_lat;
  logic [CNT_W-1:0]  lx_cnt;
  logic [CNT_W-1:0]  lx_nxt;
  logic [CNT_W-1:0]  hold_cnt;
  logic [CNT_W-1:0]  blink_cnt;
  logic [CNT_W-1:0]  blink_nxt;
  logic [DIVD_W-1:0] dividend;
  logic              cnt_frame;
  logic              win_done;
  logic              lx_trip;
  logic              hold_done;
  logic              res_alarm;
  logic              res_warn;
  logic              beep_nxt;
  level_e            state;
  level_e            state_nxt;

  assign cnt_frame = frame_start & eye_valid;
  assign win_done  = cnt_frame &&
    (win_cnt == CNT_W'(WIN_FRAMES - 1));
  assign close_lat = close_cnt + CNT_W'(eye_closed);
  assign dividend  = DIVD_W'(close_lat) * DIVD_W'(PCT_SCALE);

  assign hold_done = (state == LVL_HOLD) && frame_start &&
    (hold_cnt == CNT_W'(HOLD_FRAMES - 1));

  always_comb begin
    lx_nxt = lx_cnt;
    if (cnt_frame)
      lx_nxt = eye_closed ? sat_inc(lx_cnt) : '0;
    if (hold_done)
      lx_nxt = '0;
  end

  // Trip on the frame itself so a coincident ack loses.
  assign lx_trip   = lx_nxt > CNT_W'(LX_FRAMES);
  assign res_alarm = perclos_vld &&
    (perclos_pct >= PCT_W'(ALARM_PCT));
  assign res_warn  = perclos_vld &&
    (perclos_pct >= PCT_W'(WARN_PCT));

  perclos_div u_div (
    .module_clk   (module_clk),
    .module_rst_n (module_rst_n),
    .start        (win_done),
    .dividend     (dividend),
    .divisor      (CNT_W'(WIN_FRAMES)),
    .done         (perclos_vld),
    .quotient     (perclos_pct)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      LVL_NORMAL: begin
        if (lx_trip || res_alarm)
          state_nxt = LVL_ALARM;
        else if (res_warn)
          state_nxt = LVL_WARN;
      end
      LVL_WARN: begin
        if (lx_trip || res_alarm)
          state_nxt = LVL_ALARM;
        else if ((perclos_vld && !res_warn) || ack_key)
          state_nxt = LVL_NORMAL;
      end
      LVL_ALARM: begin
        if (ack_key)
          state_nxt = LVL_HOLD;
      end
      LVL_HOLD: begin
        if (hold_done)
          state_nxt = LVL_NORMAL;
      end
    endcase
  end

  always_comb begin
    beep_nxt  = 1'b1;
    blink_nxt = '0;
    unique case (1'b1)
      state_nxt == LVL_ALARM:
        beep_nxt = 1'b0;
      state_nxt == LVL_WARN && state != LVL_WARN:
        beep_nxt = 1'b0;
      state_nxt == LVL_WARN && state == LVL_WARN: begin
        beep_nxt  = beep;
        blink_nxt = blink_cnt;
        if (frame_start) begin
          if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
            beep_nxt  = ~beep;
            blink_nxt = '0;
          end else begin
            blink_nxt = blink_cnt + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge module_clk or negedge module_rst_n) begin
    if (!module_rst_n) begin
      win_cnt   <= '0;
      close_cnt <= '0;
    end else if (win_done) begin
      win_cnt   <= '0;
      close_cnt <= '0;
    end else if (cnt_frame) begin
      win_cnt   <= win_cnt + CNT_W'(1);
      close_cnt <= close_lat;
    end
  end

  always_ff @(posedge module_clk or negedge module_rst_n) begin
    if (!module_rst_n) begin
      hold_cnt <= '0;
    end else if (state == LVL_ALARM && ack_key) begin
      hold_cnt <= '0;
    end else if (state == LVL_HOLD && frame_start) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge module_clk or negedge module_rst_n) begin
    if (!module_rst_n) begin
      state     <= LVL_NORMAL;
      beep      <= 1'b1;
      blink_cnt <= '0;
      lx_cnt    <= '0;
    end else begin
      state     <= state_nxt;
      beep      <= beep_nxt;
      blink_cnt <= blink_nxt;
      lx_cnt    <= lx_nxt;
    end
  end

  assign alarm_level = state;

endmodule

// File: tb/tb_fatigue_alarm_ctrl.sv
// tb_fatigue_alarm_ctrl: directed scenarios plus random traffic,
// compared every cycle against a frame-level behavioural model.
module tb_fatigue_alarm_ctrl;

  localparam int WIN   = 100;
  localparam int WPCT  = 15;
  localparam int APCT  = 40;
  localparam int LX    = 5;
  localparam int HOLD  = 10;
  localparam int BLINK = 3;

  logic       module_clk   = 1'b0;
  logic       module_rst_n = 1'b1;
  logic       frame_start  = 1'b0;
  logic       eye_valid    = 1'b0;
  logic       eye_closed   = 1'b0;
  logic       ack_key      = 1'b0;
  logic       beep;
  logic [1:0] alarm_level;
  logic [6:0] perclos_pct;
  logic       perclos_vld;

  int checks = 0;
  int errors = 0;

  always #5 module_clk = ~module_clk;

  fatigue_alarm_ctrl #(
    .WIN_FRAMES   (WIN),
    .WARN_PCT     (WPCT),
    .ALARM_PCT    (APCT),
    .LX_FRAMES    (LX),
    .HOLD_FRAMES  (HOLD),
    .BLINK_FRAMES (BLINK)
  ) dut (
    .module_clk   (module_clk),
    .module_rst_n (module_rst_n),
    .frame_start  (frame_start),
    .eye_valid    (eye_valid),
    .eye_closed   (eye_closed),
    .ack_key      (ack_key),
    .beep         (beep),
    .alarm_level  (alarm_level),
    .perclos_pct  (perclos_pct),
    .perclos_vld  (perclos_vld)
  );

  // ---- behavioural model (frame/window level) ----
  int m_lvl, m_beep, m_pct, m_vld;
  int m_win, m_close, m_lx, m_hold, m_wfs, m_edge;
  int q_due[$];
  int q_val[$];

  task automatic m_reset();
    m_lvl = 0; m_beep = 1; m_pct = 0; m_vld = 0;
    m_win = 0; m_close = 0; m_lx = 0; m_hold = 0;
    m_wfs = 0; m_edge = 0;
    q_due.delete();
    q_val.delete();
  endtask

  task automatic m_step();
    bit cnt, trip, r_al, r_wa;
    int lxn, nxt;
    m_edge++;
    cnt = frame_start && eye_valid;
    lxn = m_lx;
    if (cnt)
      lxn = eye_closed ? ((m_lx < 8191) ? m_lx + 1 : 8191) : 0;
    trip = lxn > LX;
    r_al = m_vld != 0 && m_pct >= APCT;
    r_wa = m_vld != 0 && m_pct >= WPCT;
    nxt = m_lvl;
    case (m_lvl)
      0: if (trip || r_al) nxt = 2;
         else if (r_wa) nxt = 1;
      1: if (trip || r_al) nxt = 2;
         else if ((m_vld != 0 && !r_wa) || ack_key) nxt = 0;
      2: if (ack_key) begin nxt = 3; m_hold = 0; end
      default: if (frame_start) begin
        m_hold++;
        if (m_hold == HOLD) begin nxt = 0; lxn = 0; end
      end
    endcase
    // WARN beep: parity of completed blink periods since entry
    if (nxt == 1) begin
      if (m_lvl != 1) m_wfs = 0;
      else if (frame_start) m_wfs++;
      m_beep = (m_wfs / BLINK) % 2;
    end else begin
      m_beep = (nxt == 2) ? 0 : 1;
    end
    m_lvl = nxt;
    m_lx  = lxn;
    m_vld = 0;
    if (q_due.size() > 0 && q_due[0] == m_edge) begin
      m_vld = 1;
      m_pct = q_val[0];
      void'(q_due.pop_front());
      void'(q_val.pop_front());
    end
    if (cnt) begin
      m_win++;
      m_close += int'(eye_closed);
      if (m_win == WIN) begin
        q_due.push_back(m_edge + 19);
        q_val.push_back(m_close * 100 / WIN);
        m_win = 0;
        m_close = 0;
      end
    end
  endtask

  always @(posedge module_clk or negedge module_rst_n) begin
    if (!module_rst_n) m_reset();
    else m_step();
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge module_clk) begin
    chk("cyc_alarm_level", int'(alarm_level), m_lvl);
    chk("cyc_beep", int'(beep), m_beep);
    chk("cyc_perclos_vld", int'(perclos_vld), m_vld);
    chk("cyc_perclos_pct", int'(perclos_pct), m_pct);
  end

  // ---- stimulus helpers ----
  task automatic tick();
    @(posedge module_clk);
    #1;
  endtask

  task automatic send_frame(input bit v, input bit c, input bit a);
    frame_start = 1'b1;
    eye_valid   = v;
    eye_closed  = c;
    ack_key     = a;
    tick();
    frame_start = 1'b0;
    eye_valid   = 1'b0;
    eye_closed  = 1'b0;
    ack_key     = 1'b0;
  endtask

  task automatic do_reset();
    module_rst_n = 1'b0;
    tick();
    tick();
    module_rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_vld(input int exp_pct);
    int lat = 1;
    while (!perclos_vld && lat < 40) begin
      tick();
      lat++;
    end
    chk("vld_latency", lat, 20);
    chk("perclos_pct", int'(perclos_pct), exp_pct);
    chk("model_pct", m_pct, exp_pct);
  endtask

  task automatic ack_hold();
    ack_key = 1'b1;
    tick();
    ack_key = 1'b0;
    chk("lvl_hold", int'(alarm_level), 3);
    for (int i = 0; i < HOLD; i++) begin
      send_frame(i % 2 == 1, 1'b1, 1'b0);
      if (i == HOLD - 2)
        chk("lvl_still_hold", int'(alarm_level), 3);
      if (i < HOLD - 1) tick();
    end
    chk("lvl_after_hold", int'(alarm_level), 0);
    chk("beep_after_hold", int'(beep), 1);
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p;
    bit seen;
    m_reset();
    #2 module_rst_n = 1'b0;
    tick();
    tick();
    chk("rst_level", int'(alarm_level), 0);
    chk("rst_beep", int'(beep), 1);
    chk("rst_pct", int'(perclos_pct), 0);
    chk("rst_vld", int'(perclos_vld), 0);
    module_rst_n = 1'b1;
    tick();

    // Scenario 1: 20 isolated closed frames -> 20% WARN
    for (int i = 0; i < WIN; i++) begin
      send_frame(1'b1, i % 5 == 4, 1'b0);
      if (i < WIN - 1) tick();
    end
    wait_vld(20);
    tick();
    chk("s1_level", int'(alarm_level), 1);
    chk("s1_beep_entry", int'(beep), 0);
    for (int i = 0; i < BLINK; i++) begin
      send_frame(1'b1, 1'b0, 1'b0);
      if (i == BLINK - 2) chk("s1_beep_pre", int'(beep), 0);
      tick();
    end
    chk("s1_beep_toggle", int'(beep), 1);

    // Scenario 5: ack with the 6th closed frame in WARN
    for (int i = 0; i < LX; i++) begin
      send_frame(1'b1, 1'b1, 1'b0);
      tick();
    end
    chk("s5_still_warn", int'(alarm_level), 1);
    send_frame(1'b1, 1'b1, 1'b1);
    chk("s5_alarm", int'(alarm_level), 2);
    chk("s5_beep", int'(beep), 0);
    tick();
    ack_hold();

    // Scenario 2: 6 consecutive closed frames from NORMAL
    for (int i = 0; i <= LX; i++) begin
      if (i == LX) chk("s2_pre_level", int'(alarm_level), 0);
      send_frame(1'b1, 1'b1, 1'b0);
      if (i < LX) tick();
    end
    chk("s2_alarm", int'(alarm_level), 2);
    chk("s2_beep", int'(beep), 0);
    tick();
    ack_hold();

    // Scenario 3: 45% alarm, then a 10% window keeps ALARM
    do_reset();
    for (int i = 0; i < WIN; i++) begin
      send_frame(1'b1, (i % 2 == 0) && i < 90, 1'b0);
      if (i < WIN - 1) tick();
    end
    wait_vld(45);
    tick();
    chk("s3_alarm", int'(alarm_level), 2);
    for (int i = 0; i < WIN; i++) begin
      send_frame(1'b1, i % 10 == 0, 1'b0);
      if (i < WIN - 1) tick();
    end
    wait_vld(10);
    tick();
    chk("s3_keep_alarm", int'(alarm_level), 2);
    ack_hold();

    // Scenario 4: invalid frames interleaved
    do_reset();
    for (int i = 0; i < WIN; i++) begin
      send_frame(1'b1, i <= LX, 1'b0);
      if (i == LX) chk("s4_lx_alarm", int'(alarm_level), 2);
      if (i < 50) send_frame(1'b0, i % 2 == 1, 1'b0);
      if (i == LX - 1) chk("s4_lx_hold", int'(alarm_level), 0);
    end
    wait_vld(6);

    // Scenario 6: reset pulse mid-divide
    do_reset();
    for (int i = 0; i < WIN; i++) begin
      send_frame(1'b1, (i % 2 == 0) && i < 90, 1'b0);
      if (i < WIN - 1) tick();
    end
    repeat (8) tick();
    module_rst_n = 1'b0;
    tick();
    module_rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      tick();
      if (perclos_vld) seen = 1'b1;
    end
    chk("s6_no_vld", int'(seen), 0);
    chk("s6_pct", int'(perclos_pct), 0);
    chk("s6_level", int'(alarm_level), 0);
    chk("s6_beep", int'(beep), 1);

    // Random traffic
    do_reset();
    p = 0;
    for (int c = 0; c < 6000; c++) begin
      if (c % 250 == 0) p = $urandom_range(0, 50);
      frame_start = $urandom_range(0, 1) == 1;
      eye_valid   = $urandom_range(0, 9) < 8;
      eye_closed  = $urandom_range(0, 99) < p;
      ack_key     = $urandom_range(0, 39) == 0;
      tick();
    end
    frame_start = 1'b0;
    eye_valid   = 1'b0;
    eye_closed  = 1'b0;
    ack_key     = 1'b0;
    repeat (30) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
